// File: rtl/cnn_axi_rd_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cnn_axi_rd_arbiter_if
//  Brief    : Requester-side and AXI3 read-side bundle for the CNN read arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface cnn_axi_rd_arbiter_if #(
    parameter int NUM_REQ      = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int ID_MAX_WIDTH = 16
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // requester side
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*4-1:0]          req_len;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic [1:0]                    rsp_resp;
    logic                          rsp_last;
    logic [ID_W-1:0]               rsp_id;
    logic                          rsp_ready;

    // AXI3 AR channel
    logic [ID_MAX_WIDTH-1:0]       arid;
    logic [ADDR_WIDTH-1:0]         araddr;
    logic [3:0]                    arlen;
    logic [2:0]                    arsize;
    logic [1:0]                    arburst;
    logic                          arvalid;
    logic                          arready;

    // AXI3 R channel
    logic [ID_MAX_WIDTH-1:0]       rid;
    logic [DATA_WIDTH-1:0]         rdata;
    logic [1:0]                    rresp;
    logic                          rlast;
    logic                          rvalid;
    logic                          rready;

    modport master (
        input  req_valid, req_addr, req_len, rsp_ready,
        input  arready, rid, rdata, rresp, rlast, rvalid,
        output req_ready, rsp_valid, rsp_data, rsp_resp, rsp_last, rsp_id,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready
    );

    modport slave (
        output req_valid, req_addr, req_len, rsp_ready,
        output arready, rid, rdata, rresp, rlast, rvalid,
        input  req_ready, rsp_valid, rsp_data, rsp_resp, rsp_last, rsp_id,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready
    );
endinterface
`default_nettype wire

// File: rtl/cnn_axi_rd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cnn_axi_rd_arbiter
//  Brief    : Round-robin share of one AXI3 read port, one burst in flight.
//  Revision : 1.0  initial release
// ============================================================================
module cnn_axi_rd_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int ID_MAX_WIDTH = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    cnn_axi_rd_arbiter_if.master   bus,
    output logic                   o_err
);
    localparam int             ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ID_W:0]  C_NUM        = (ID_W+1)'(NUM_REQ);
    localparam logic [2:0]     C_ARSIZE     = 3'($clog2(DATA_WIDTH/8));
    localparam logic [1:0]     C_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [ID_W-1:0]         r_rr_ptr;
    logic [ID_W-1:0]         r_grant;
    logic [ID_W-1:0]         w_gnt;
    logic [ID_W-1:0]         w_next_ptr;
    logic                    w_any;

    logic [NUM_REQ-1:0]      r_req_ready;
    logic                    r_arvalid;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic [3:0]              r_arlen;
    logic [ID_MAX_WIDTH-1:0] r_arid;
    logic [2:0]              r_arsize;
    logic [1:0]              r_arburst;
    logic [3:0]              r_cnt;
    logic                    r_err;

    logic                    w_in_data;
    logic                    w_hs;
    logic                    w_grant_now;
    logic                    w_issue_ar;
    logic                    w_ar_done;
    logic                    w_beat_err;

    // First valid requester at or after r_rr_ptr, wrapping at NUM_REQ.
    always_comb begin : p_arb
        logic [ID_W:0] v_idx;
        w_any = 1'b0;
        w_gnt = '0;
        v_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(i);
            if (v_idx >= C_NUM) begin
                v_idx = v_idx - C_NUM;
            end
            if (!w_any && bus.req_valid[v_idx[ID_W-1:0]]) begin
                w_any = 1'b1;
                w_gnt = v_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin : p_next_ptr
        logic [ID_W:0] v_inc;
        v_inc = {1'b0, r_grant} + (ID_W+1)'(1);
        if (v_inc >= C_NUM) begin
            v_inc = '0;
        end
        w_next_ptr = v_inc[ID_W-1:0];
    end

    // A pending req_ready pulse blocks re-arbitration while the grant is announced.
    assign w_grant_now = (r_state == ST_IDLE) && !(|r_req_ready) && w_any;
    assign w_issue_ar  = (r_state == ST_IDLE) && (|r_req_ready);
    assign w_ar_done   = (r_state == ST_ADDR) && r_arvalid && bus.arready;
    assign w_in_data   = (r_state == ST_DATA);
    assign w_hs        = w_in_data && bus.rvalid && bus.rsp_ready;

    assign w_beat_err  = w_hs && ((bus.rlast && (r_cnt != r_arlen)) ||
                                  (!bus.rlast && (r_cnt == r_arlen)) ||
                                  (bus.rid != ID_MAX_WIDTH'(r_grant)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_issue_ar)           w_state_nxt = ST_ADDR;
            ST_ADDR: if (w_ar_done)            w_state_nxt = ST_DATA;
            ST_DATA: if (w_hs && bus.rlast)    w_state_nxt = ST_IDLE;
            default:                           w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_req_ready <= '0;
            r_arvalid   <= 1'b0;
            r_araddr    <= '0;
            r_arlen     <= '0;
            r_arid      <= '0;
            r_arsize    <= '0;
            r_arburst   <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
        end else begin
            r_req_ready <= '0;
            if (w_grant_now) begin
                r_req_ready <= NUM_REQ'(1) << w_gnt;
                r_grant     <= w_gnt;
                r_araddr    <= bus.req_addr[w_gnt*ADDR_WIDTH +: ADDR_WIDTH];
                r_arlen     <= bus.req_len[w_gnt*4 +: 4];
            end
            if (w_issue_ar) begin
                r_arvalid <= 1'b1;
                r_arid    <= ID_MAX_WIDTH'(r_grant);
                r_arsize  <= C_ARSIZE;
                r_arburst <= C_BURST_INCR;
                r_cnt     <= '0;
            end
            if (w_ar_done) begin
                r_arvalid <= 1'b0;
            end
            if (w_hs) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_hs && bus.rlast) begin
                r_rr_ptr <= w_next_ptr;
            end
            // Sticky until reset; bad rresp codes are only forwarded.
            if (w_beat_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.arvalid   = r_arvalid;
    assign bus.araddr    = r_araddr;
    assign bus.arlen     = r_arlen;
    assign bus.arid      = r_arid;
    assign bus.arsize    = r_arsize;
    assign bus.arburst   = r_arburst;

    assign bus.rsp_valid = w_in_data && bus.rvalid;
    assign bus.rready    = w_in_data && bus.rsp_ready;
    assign bus.rsp_data  = bus.rdata;
    assign bus.rsp_resp  = bus.rresp;
    assign bus.rsp_last  = bus.rlast;
    assign bus.rsp_id    = r_grant;

    assign o_err = r_err;
endmodule
`default_nettype wire
